// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial subtractor, diff = a - b mod 2^N, DIGIT bits per cycle
module serial_subtractor #(
    parameter int N     = 16,
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         ovf,
    output logic         zero
);

    localparam int S  = N / DIGIT;
    localparam int CW = (S > 1) ? $clog2(S) : 1;

    if (DIGIT < 1 || DIGIT > N || (N % DIGIT) != 0) begin : g_bad_param
        $error("serial_subtractor: DIGIT must divide N and lie in 1..N");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic [N-1:0]    res_sh;
    logic [N-1:0]    res_nx;
    logic            borrow;
    logic            a_msb;
    logic            b_msb;
    logic [CW-1:0]   count;
    logic [DIGIT-1:0] d;
    logic            bo;
    logic            last;

    assign in_ready = (state == IDLE) && rst_n;
    assign last     = (count == CW'(S - 1));

    always_comb begin
        {bo, d} = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    end

    // New digit enters at the MSB end so the LSB digit, computed first, ends up at bit 0.
    if (DIGIT == N) begin : g_full
        always_comb res_nx = d;
    end else begin : g_part
        always_comb res_nx = {d, res_sh[N-1:DIGIT]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            count      <= '0;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        a_msb  <= a[N-1];
                        b_msb  <= b[N-1];
                        borrow <= 1'b0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    borrow <= bo;
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_nx;
                    count  <= count + CW'(1);
                    if (last) begin
                        diff       <= res_nx;
                        borrow_out <= bo;
                        ovf        <= (a_msb != b_msb) && (res_nx[N-1] != a_msb);
                        zero       <= (res_nx == '0);
                        out_valid  <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - bench for serial_subtractor at DIGIT = 1, 4 and 16
module tb_serial_subtractor;

    localparam int N  = 16;
    localparam int NI = 3;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           e;
    } op_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;

    logic         ir     [NI];
    logic         ov     [NI];
    logic         bo_v   [NI];
    logic         ovf_v  [NI];
    logic         zero_v [NI];
    logic [N-1:0] diff_v [NI];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    op_t  pq [NI][$];
    logic prev_ov [NI];
    int   n_ops [NI];

    function automatic int dg(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        serial_subtractor #(.N(N), .DIGIT(D)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (ir[g]),
            .a          (a),
            .b          (b),
            .out_valid  (ov[g]),
            .out_ready  (out_ready),
            .diff       (diff_v[g]),
            .borrow_out (bo_v[g]),
            .ovf        (ovf_v[g]),
            .zero       (zero_v[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden result packed as {borrow, ovf, zero, diff}.
    function automatic logic [N+2:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] dd;
        logic         br;
        logic         of;
        dd = x - y;
        br = (x < y);
        of = (x[N-1] != y[N-1]) && (dd[N-1] != x[N-1]);
        return {br, of, (dd == '0), dd};
    endfunction

    function automatic logic [N+2:0] res_of(input int g);
        return {bo_v[g], ovf_v[g], zero_v[g], diff_v[g]};
    endfunction

    // Runs at the negedge: handshakes seen here complete on the following posedge.
    task automatic monitor();
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                pq[g].delete();
                prev_ov[g] = 1'b0;
            end else begin
                if (ov[g] && !prev_ov[g]) begin
                    check($sformatf("d%0d_pending", dg(g)), 32'(pq[g].size() > 0), 32'd1);
                    if (pq[g].size() > 0)
                        check($sformatf("d%0d_latency", dg(g)), 32'(cyc - pq[g][0].e), 32'(N / dg(g)));
                end
                if (ov[g] && out_ready && pq[g].size() > 0) begin
                    check($sformatf("d%0d_result", dg(g)), 32'(res_of(g)),
                          32'(model(pq[g][0].a, pq[g][0].b)));
                    void'(pq[g].pop_front());
                    n_ops[g]++;
                end
                if (in_valid && ir[g]) pq[g].push_back('{a, b, cyc + 1});
                prev_ov[g] = ov[g];
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ir[1] && k < 200) begin
            tick();
            k++;
        end
        check("ready_timeout", 32'(ir[1]), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [N-1:0] xa, input logic [N-1:0] xb,
                         input logic [N-1:0] ed, input logic eb, input logic eo, input logic ez);
        wait_ready();
        a = xa;
        b = xb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check({tag, "_early"}, 32'(ov[1]), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(ov[1]), 32'd1);
        check({tag, "_res"}, 32'(res_of(1)), 32'({eb, eo, ez, ed}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(ov[1]), 32'd0);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom % 8)
            0:       return '0;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        for (int g = 0; g < NI; g++) begin
            n_ops[g]   = 0;
            prev_ov[g] = 1'b0;
        end
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_ir_d%0d", dg(g)), 32'(ir[g]), 32'd0);
            check($sformatf("rst_ov_d%0d", dg(g)), 32'(ov[g]), 32'd0);
            check($sformatf("rst_res_d%0d", dg(g)), 32'(res_of(g)), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("post_rst_ir", 32'(ir[1]), 32'd1);

        do_op("sub_1234", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b0);
        do_op("sub_0_1",  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        do_op("sub_8000", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        do_op("sub_5555", 16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1);
        do_op("sub_7fff", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Result held under back-pressure while other operands are offered.
        wait_ready();
        a = 16'hA5A5;
        b = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("hold_valid", 32'(ov[1]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = N'($urandom);
            b = N'($urandom);
            tick();
            check("hold_ov", 32'(ov[1]), 32'd1);
            check("hold_ir", 32'(ir[1]), 32'd0);
            check("hold_res", 32'(res_of(1)), 32'h9371);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_drop", 32'(ov[1]), 32'd0);
        check("hold_keep", 32'(res_of(1)), 32'h9371);

        // Reset in the middle of RUN discards the operation.
        wait_ready();
        a = 16'h1111;
        b = 16'h2222;
        in_valid = 1'b1;
        tick();
        a = 16'hDEAD;
        b = 16'hBEEF;
        tick();
        tick();
        check("run_ir", 32'(ir[1]), 32'd0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_mid_ir", 32'(ir[1]), 32'd1);
        check("rst_mid_ov", 32'(ov[1]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_no_ov", 32'(ov[1]), 32'd0);
        end
        do_op("sub_00ff", 16'h00FF, 16'h0F00, 16'hF1FF, 1'b1, 1'b0, 1'b0);

        for (int c = 0; c < 24000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            a         = pick();
            b         = pick();
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("d%0d_lost", dg(g)), 32'(pq[g].size()), 32'd0);
            check($sformatf("d%0d_ops", dg(g)), 32'(n_ops[g] > 100), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
